// File: rtl/exe_muldiv_seq_pkg.sv
// Shared constants for the EXE-stage multiply/divide sequencer:
// command encodings, FSM states and small command-decode helpers.
package exe_muldiv_seq_pkg;

  localparam int MULDIV_OP_LEN = 2;

  typedef enum logic [MULDIV_OP_LEN-1:0] {
    MULDIV_MULU = 2'b00,
    MULDIV_DIVU = 2'b01,
    MULDIV_MUL  = 2'b10,
    MULDIV_DIV  = 2'b11
  } muldiv_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic op_is_signed(input muldiv_op_e o);
    return o[1];
  endfunction

  function automatic logic op_is_div(input muldiv_op_e o);
    return o[0];
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational two's-complement sign correction. Used once to turn
// signed operands into magnitudes and once to apply result signs.
// wide_i=1 treats {hi,lo} as one double-width value negated by neg_hi_i.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] hi_i,
  input  logic [W-1:0] lo_i,
  input  logic         neg_hi_i,
  input  logic         neg_lo_i,
  input  logic         wide_i,
  output logic [W-1:0] hi_o,
  output logic [W-1:0] lo_o
);

  logic [2*W-1:0] wide_neg;

  // Conditional negation, either per half or across the full pair
  always_comb begin
    wide_neg = -{hi_i, lo_i};
    hi_o     = hi_i;
    lo_o     = lo_i;
    if (wide_i) begin
      if (neg_hi_i) {hi_o, lo_o} = wide_neg;
    end else begin
      if (neg_hi_i) hi_o = -hi_i;
      if (neg_lo_i) lo_o = -lo_i;
    end
  end

endmodule

// File: rtl/exe_muldiv_seq.sv
// Multi-cycle MUL/DIV sequencer beside the EXE ALU: one bit per cycle,
// result committed to HI/LO on entry to DONE, stall held while running.
// Optional build macro: MULDIV_EARLY_TERM_EN (MUL/MULU leave RUN as soon
// as no multiplier bits remain set).
module exe_muldiv_seq
  import exe_muldiv_seq_pkg::*;
#(
  parameter int WORD_LEN = 32,
  parameter int CNT_W    = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          op,
  input  logic [WORD_LEN-1:0] src_a,
  input  logic [WORD_LEN-1:0] src_b,
  input  logic                flush,
  output logic                stall,
  output logic                busy,
  output logic                done,
  output logic [WORD_LEN-1:0] hi,
  output logic [WORD_LEN-1:0] lo
);

  localparam int W = WORD_LEN;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORD_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2*W:0]     acc_q, acc_d;
  logic [W-1:0]     opnd_q, opnd_d, araw_q, araw_d, hi_q, hi_d, lo_q, lo_d;
  logic             div_q, div_d, nega_q, nega_d, negb_q, negb_d;
  logic             stall_c;

  muldiv_op_e   op_in;
  logic         in_neg_a, in_neg_b;
  logic [W-1:0] a_mag, b_mag;

  assign op_in    = muldiv_op_e'(op);
  assign in_neg_a = op_is_signed(op_in) & src_a[W-1];
  assign in_neg_b = op_is_signed(op_in) & src_b[W-1];

  muldiv_sign_fix #(.W(W)) u_fix_in (
    .hi_i(src_a), .lo_i(src_b), .neg_hi_i(in_neg_a), .neg_lo_i(in_neg_b),
    .wide_i(1'b0), .hi_o(a_mag), .lo_o(b_mag)
  );

  logic [W:0]       mul_sum, div_shift;
  logic [W+1:0]     div_diff;
  logic [2*W:0]     mul_step, div_step, acc_step;
  logic [CNT_W-1:0] cnt_step;

  // One iteration: shift-add for MUL, restoring subtract for DIV.
  // acc = {partial product | multiplier} or {partial remainder | quotient}
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + {1'b0, opnd_q};
    mul_step  = acc_q[0] ? {1'b0, mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W:1]};
    div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    div_diff  = {1'b0, div_shift} - {2'b00, opnd_q};
    if (div_diff[W+1]) div_step = {div_shift, acc_q[W-2:0], 1'b0};
    else               div_step = {div_diff[W:0], acc_q[W-2:0], 1'b1};
    acc_step  = div_q ? div_step : mul_step;
    cnt_step  = cnt_q - CNT_ONE;
  end

  logic           early_exit;
  logic [2*W-1:0] prod_al;

`ifdef MULDIV_EARLY_TERM_EN
  logic mplr_left;

  // Early exit: the product sits cnt_step bits too high, so realign it
  always_comb begin
    mplr_left = 1'b0;
    for (int unsigned i = 0; i < W; i++) begin
      if (i < 32'(cnt_step)) mplr_left = mplr_left | acc_step[i];
    end
    early_exit = !div_q && !mplr_left;
    prod_al    = (2*W)'(acc_step >> cnt_step);
  end
`else
  assign early_exit = 1'b0;
  assign prod_al    = acc_step[2*W-1:0];
`endif

  logic [W-1:0] res_hi_raw, res_lo_raw, res_hi, res_lo;
  logic         res_neg_hi, res_neg_lo;

  // Select raw result halves and the sign rule for each half
  always_comb begin
    res_hi_raw = div_q ? acc_step[2*W-1:W] : prod_al[2*W-1:W];
    res_lo_raw = div_q ? acc_step[W-1:0]   : prod_al[W-1:0];
    res_neg_hi = div_q ? nega_q : (nega_q ^ negb_q);
    res_neg_lo = nega_q ^ negb_q;
  end

  muldiv_sign_fix #(.W(W)) u_fix_out (
    .hi_i(res_hi_raw), .lo_i(res_lo_raw), .neg_hi_i(res_neg_hi),
    .neg_lo_i(res_neg_lo), .wide_i(!div_q), .hi_o(res_hi), .lo_o(res_lo)
  );

  // Next-state, operand capture, iteration and HI/LO commit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opnd_d  = opnd_q;
    araw_d  = araw_q;
    div_d   = div_q;
    nega_d  = nega_q;
    negb_d  = negb_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    stall_c = 1'b0;
    unique case (state_q)
      MD_IDLE: begin
        stall_c = start;
        if (start && !flush) begin
          div_d   = op_is_div(op_in);
          nega_d  = in_neg_a;
          negb_d  = in_neg_b;
          araw_d  = src_a;
          cnt_d   = CNT_LOAD;
          opnd_d  = op_is_div(op_in) ? b_mag : a_mag;
          acc_d   = {{(W+1){1'b0}}, op_is_div(op_in) ? a_mag : b_mag};
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        stall_c = 1'b1;
        cnt_d   = cnt_step;
        acc_d   = acc_step;
        if (flush) begin
          state_d = MD_IDLE;
        end else if (cnt_q == CNT_ONE || early_exit) begin
          state_d = MD_DONE;
          if (div_q && opnd_q == '0) begin
            hi_d = araw_q;
            lo_d = '1;
          end else begin
            hi_d = res_hi;
            lo_d = res_lo;
          end
        end
      end
      MD_DONE: state_d = MD_IDLE;
      default: state_d = MD_IDLE;
    endcase
  end

  // State and datapath registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      araw_q  <= '0;
      div_q   <= 1'b0;
      nega_q  <= 1'b0;
      negb_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      opnd_q  <= opnd_d;
      araw_q  <= araw_d;
      div_q   <= div_d;
      nega_q  <= nega_d;
      negb_q  <= negb_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign stall = stall_c & ~rst;
  assign busy  = (state_q != MD_IDLE);
  assign done  = (state_q == MD_DONE);
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
